// File: rtl/pfu_rx.sv
// pfu_rx -- receive-side power fix unit.
// Scales each complex FFT output sample by 181/4096 (~1/sqrt(512)) using
// shift-and-add only, then rounds or floors, saturates symmetrically to
// +/-(2^(DO_W-1)-1) and tags the sample with its subcarrier index and
// symbol start/end markers. Four register stages from di_vld to do_vld.
// Build option: define PFU_RX_ROUND_EN for round-half-up, otherwise floor.
module pfu_rx #(
    parameter int DI_W = 18,
    parameter int DO_W = 12,
    parameter int NFFT = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [DI_W-1:0]  di_re,
    input  logic signed [DI_W-1:0]  di_im,
    input  logic                    di_vld,
    output logic signed [DO_W-1:0]  do_re,
    output logic signed [DO_W-1:0]  do_im,
    output logic                    do_vld,
    output logic [$clog2(NFFT)-1:0] do_idx,
    output logic                    do_sop,
    output logic                    do_eop,
    output logic                    sat_flag
);

    localparam int PW      = DI_W + 8;
    localparam int IW      = $clog2(NFFT);
    localparam int SAT_MAX = (1 << (DO_W - 1)) - 1;

    localparam logic signed [PW-1:0] SAT_HI = PW'(SAT_MAX);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-SAT_MAX);
    localparam logic [IW-1:0]        IDX_LAST = IW'(NFFT - 1);
`ifdef PFU_RX_ROUND_EN
    localparam logic signed [PW-1:0] RND_HALF = PW'(2048);
`endif

    // Component 0 is the real path, component 1 the imaginary path.
    logic signed [PW-1:0] x_ext  [2];
    logic signed [PW-1:0] t_q    [2][5];
    logic signed [PW-1:0] p1_q   [2];
    logic signed [PW-1:0] p2_q   [2];
    logic signed [PW-1:0] s_q    [2];
    logic signed [PW-1:0] shf_d  [2];
    logic signed [DO_W-1:0] y_d  [2];
    logic                 sat_d  [2];

    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q [3];
    logic          vld_q [3];

    // Sign-extend both input components to the internal product width.
    always_comb begin
        x_ext[0] = PW'(di_re);
        x_ext[1] = PW'(di_im);
    end

    // Next subcarrier index: advances only on accepted samples, wraps at NFFT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (di_vld) begin
            cnt_d = (cnt_q == IDX_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Stage 4 datapath: scale by 2^-12, then clamp to the symmetric output range.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        for (int c = 0; c < 2; c++) begin
`ifdef PFU_RX_ROUND_EN
            shf_d[c] = (s_q[c] + RND_HALF) >>> 12;
`else
            shf_d[c] = s_q[c] >>> 12;
`endif
            sat_d[c] = 1'b0;
            y_d[c]   = shf_d[c][DO_W-1:0];
            if (shf_d[c] > SAT_HI) begin
                y_d[c]   = SAT_HI[DO_W-1:0];
                sat_d[c] = 1'b1;
            end else if (shf_d[c] < SAT_LO) begin
                y_d[c]   = SAT_LO[DO_W-1:0];
                sat_d[c] = 1'b1;
            end
        end
    end

    // Stages 1-3: shifted terms, partial sums, full product; index/valid travel alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (!rst_n) begin
            // NOTE: the pipeline arrays are cleared on reset so discarded in-flight samples can never leak out.
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 5; k++) t_q[c][k] <= '0;
                p1_q[c] <= '0;
                p2_q[c] <= '0;
                s_q[c]  <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                vld_q[k] <= 1'b0;
                idx_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (di_vld) begin
                    t_q[c][0] <= x_ext[c] <<< 7;
                    t_q[c][1] <= x_ext[c] <<< 5;
                    t_q[c][2] <= x_ext[c] <<< 4;
                    t_q[c][3] <= x_ext[c] <<< 2;
                    t_q[c][4] <= x_ext[c];
                end else begin
                    for (int k = 0; k < 5; k++) t_q[c][k] <= '0;
                end
                p1_q[c] <= t_q[c][0] + t_q[c][1];
                p2_q[c] <= t_q[c][2] + t_q[c][3] + t_q[c][4];
                s_q[c]  <= p1_q[c] + p2_q[c];
            end
            vld_q[0] <= di_vld;
            vld_q[1] <= vld_q[0];
            vld_q[2] <= vld_q[1];
            idx_q[0] <= cnt_q;
            idx_q[1] <= idx_q[0];
            idx_q[2] <= idx_q[1];
            cnt_q    <= cnt_d;
        end
    end

    // Stage 4 output register: data and markers only when valid, sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_re    <= '0;
            do_im    <= '0;
            do_vld   <= 1'b0;
            do_idx   <= '0;
            do_sop   <= 1'b0;
            do_eop   <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            do_vld <= vld_q[2];
            if (vld_q[2]) begin
                do_re  <= y_d[0];
                do_im  <= y_d[1];
                do_idx <= idx_q[2];
                do_sop <= (idx_q[2] == '0);
                do_eop <= (idx_q[2] == IDX_LAST);
                if (sat_d[0] || sat_d[1]) sat_flag <= 1'b1;
            end else begin
                do_re  <= '0;
                do_im  <= '0;
                do_sop <= 1'b0;
                do_eop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pfu_rx.sv
// tb_pfu_rx -- self-checking bench for pfu_rx.
// Directed and $urandom stimulus; expected outputs come from an arithmetic
// model (x*181/4096, floor or round-half-up, clamp to +/-2047) held in a
// four-entry latency queue, with a symbol-index counter and sticky flag.
module tb_pfu_rx;

    localparam int DI_W = 18;
    localparam int DO_W = 12;
    localparam int NFFT = 512;
    localparam int IW   = $clog2(NFFT);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic signed [DI_W-1:0] di_re = '0;
    logic signed [DI_W-1:0] di_im = '0;
    logic                   di_vld = 1'b0;
    logic signed [DO_W-1:0] do_re;
    logic signed [DO_W-1:0] do_im;
    logic                   do_vld;
    logic [IW-1:0]          do_idx;
    logic                   do_sop;
    logic                   do_eop;
    logic                   sat_flag;

    pfu_rx #(.DI_W(DI_W), .DO_W(DO_W), .NFFT(NFFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
        .do_re(do_re), .do_im(do_im), .do_vld(do_vld),
        .do_idx(do_idx), .do_sop(do_sop), .do_eop(do_eop),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int re;
        int im;
        int idx;
        bit sat;
    } exp_t;

    exp_t pipe_q[$];
    int   mdl_cnt;
    bit   mdl_sat;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: x * 181 / 4096, floor or round-half-up, clamp to +/-2047.
    task automatic scale(input int x, output int y, output bit s);
        longint p;
        p = longint'(x) * 181;
`ifdef PFU_RX_ROUND_EN
        p = p + 2048;
`endif
        p = p >>> 12;
        s = 1'b0;
        if (p > 2047) begin
            p = 2047; s = 1'b1;
        end else if (p < -2047) begin
            p = -2047; s = 1'b1;
        end
        y = int'(p);
    endtask

    task automatic model_push(input bit v, input int r, input int i);
        exp_t e;
        bit   sr, si;
        e.vld = v; e.re = 0; e.im = 0; e.idx = 0; e.sat = 1'b0;
        if (v) begin
            scale(r, e.re, sr);
            scale(i, e.im, si);
            e.sat   = sr | si;
            e.idx   = mdl_cnt;
            mdl_cnt = (mdl_cnt + 1) % NFFT;
        end
        pipe_q.push_back(e);
    endtask

    task automatic model_clear();
        exp_t e;
        e.vld = 1'b0; e.re = 0; e.im = 0; e.idx = 0; e.sat = 1'b0;
        pipe_q.delete();
        repeat (3) pipe_q.push_back(e);
        mdl_cnt = 0;
        mdl_sat = 1'b0;
    endtask

    task automatic compare_out();
        exp_t e;
        e = pipe_q.pop_front();
        if (e.vld && e.sat) mdl_sat = 1'b1;
        check("vld", do_vld, e.vld);
        check("re",  do_re,  e.re);
        check("im",  do_im,  e.im);
        if (e.vld) check("idx", do_idx, e.idx);
        check("sop", do_sop, e.vld && e.idx == 0);
        check("eop", do_eop, e.vld && e.idx == NFFT - 1);
        check("sat", sat_flag, mdl_sat);
    endtask

    // One clock: drive, let the edge capture, then check outputs on the falling edge.
    task automatic cycle(input bit v, input int r, input int i);
        di_vld = v;
        di_re  = DI_W'(r);
        di_im  = DI_W'(i);
        @(posedge clk);
        if (rst_n) model_push(v, r, i);
        @(negedge clk);
        if (rst_n) begin
            compare_out();
        end else begin
            check("rst_vld", do_vld, 0);
            check("rst_re",  do_re,  0);
            check("rst_im",  do_im,  0);
            check("rst_idx", do_idx, 0);
            check("rst_sop", do_sop, 0);
            check("rst_eop", do_eop, 0);
            check("rst_sat", sat_flag, 0);
        end
    endtask

    function automatic int rnd_val();
        int sel;
        sel = int'($urandom_range(0, 3));
        if (sel == 0) return int'($signed(DI_W'($urandom)));
        if (sel == 1) return int'($urandom_range(0, 200)) + 46200;
        if (sel == 2) return -(int'($urandom_range(0, 200)) + 46200);
        return int'($urandom_range(0, 92000)) - 46000;
    endfunction

    task automatic apply_reset(input int ncyc);
        rst_n = 1'b0;
        model_clear();
        repeat (ncyc) cycle(1'b1, rnd_val(), rnd_val());
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and first sample: exact 1/sqrt(NFFT) scaling.
        apply_reset(2);
        cycle(1'b1, 4096, -4096);
        repeat (3) cycle(1'b0, 0, 0);
        check("t1_vld", do_vld, 1);
        check("t1_re",  do_re,  181);
        check("t1_im",  do_im,  -181);
        check("t1_sop", do_sop, 1);
        check("t1_idx", do_idx, 0);
        check("t1_sat", sat_flag, 0);

        // Rounding mode corner.
        cycle(1'b1, -1, 32767);
        repeat (3) cycle(1'b0, 0, 0);
`ifdef PFU_RX_ROUND_EN
        check("t2_re", do_re, 0);
        check("t2_im", do_im, 1448);
`else
        check("t2_re", do_re, -1);
        check("t2_im", do_im, 1447);
`endif

        // Saturation at both extremes, then the flag must stick.
        cycle(1'b1, 131071, -131072);
        repeat (3) cycle(1'b0, 0, 0);
        check("t3_re",  do_re,  2047);
        check("t3_im",  do_im,  -2047);
        check("t3_sat", sat_flag, 1);
        repeat (6) cycle(1'b1, 100, -100);
        check("t3_sticky", sat_flag, 1);

        // Invalid cycles carrying nonzero data must produce zero outputs.
        repeat (8) cycle(1'b0, 1234, -777);

        // Two full symbols with a 3-cycle bubble, starting from index 0.
        apply_reset(1);
        for (int k = 0; k < NFFT; k++) cycle(1'b1, rnd_val(), rnd_val());
        repeat (3) cycle(1'b0, rnd_val(), rnd_val());
        for (int k = 0; k < NFFT; k++) cycle(1'b1, rnd_val(), rnd_val());
        repeat (4) cycle(1'b0, 0, 0);

        // Reset at sample 200 of a symbol; stream resumes at index 0.
        for (int k = 0; k < 200; k++) cycle(1'b1, rnd_val(), rnd_val());
        apply_reset(1);
        repeat (4) cycle(1'b1, rnd_val(), rnd_val());
        check("t5_sop", do_sop, 1);
        check("t5_idx", do_idx, 0);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) cycle(1'b0, rnd_val(), rnd_val());
            else                           cycle(1'b1, rnd_val(), rnd_val());
        end
        repeat (4) cycle(1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
